// File: rtl/profile_sampler.sv
// Custom-instruction profiling sampler: periodically snapshots four counters into a FIFO read back by peek/pop.
// Optional per-entry timestamps are enabled with macro PROFILE_SAMPLER_TIMESTAMP_EN.
module profile_sampler #(
    parameter logic [7:0]  customId = 8'h00,
    parameter int unsigned DEPTH    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic [31:0] counterValue0,
    input  logic [31:0] counterValue1,
    input  logic [31:0] counterValue2,
    input  logic [31:0] counterValue3,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FILL_W  = PTR_W + 1;
    localparam int unsigned ENTRY_W = 128;

    typedef enum logic [1:0] {
        OP_PEEK   = 2'b00,
        OP_POP    = 2'b01,
        OP_CONFIG = 2'b10,
        OP_STATUS = 2'b11
    } op_e;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [31:0]        period_q, period_d, timer_q, timer_d;
    logic               armed_q, armed_d;
    logic [15:0]        ovf_q, ovf_d;
    logic               done_q, done_d;
    logic [31:0]        result_q, result_d;

    logic               accept, empty, full, is_cfg, is_pop, wrap, push_try, do_push;
    op_e                op;
    logic [ENTRY_W-1:0] head;
    logic [31:0]        rd_word;

`ifdef PROFILE_SAMPLER_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] ts_mem_q [DEPTH];
`endif

    logic unused_bits;
    assign unused_bits = ^valueA[31:5];

    // Request decode, FIFO bookkeeping and sampling timer
    always_comb begin
        accept   = start && (ciN == customId);
        op       = op_e'(valueA[3:2]);
        empty    = (fill_q == '0);
        full     = (fill_q == FILL_W'(DEPTH));
        is_cfg   = accept && (op == OP_CONFIG);
        is_pop   = accept && (op == OP_POP) && !empty;
        wrap     = armed_q && (timer_q == period_q - 32'd1);
        push_try = wrap && !is_cfg;
        do_push  = push_try && (!full || is_pop);

        head    = mem_q[rd_ptr_q];
        rd_word = head[{valueA[1:0], 5'd0} +: 32];
`ifdef PROFILE_SAMPLER_TIMESTAMP_EN
        if (valueA[4]) rd_word = ts_mem_q[rd_ptr_q];
`else
        if (valueA[4]) rd_word = 32'd0;
`endif
        if (empty) rd_word = 32'd0;

        rd_ptr_d = is_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        fill_d   = fill_q + FILL_W'(do_push) - FILL_W'(is_pop);

        period_d = period_q;
        armed_d  = armed_q;
        timer_d  = timer_q;
        ovf_d    = ovf_q;
        if (is_cfg) begin
            period_d = valueB;
            armed_d  = (valueB != 32'd0);
            timer_d  = 32'd0;
            ovf_d    = 16'd0;
        end else if (armed_q) begin
            timer_d = wrap ? 32'd0 : timer_q + 32'd1;
            if (push_try && !do_push && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
        end

        done_d   = accept;
        result_d = 32'd0;
        if (accept) begin
            case (op)
                OP_PEEK, OP_POP: result_d = rd_word;
                OP_CONFIG:       result_d = 32'd0;
                OP_STATUS:       result_d = {ovf_q, 5'b0, armed_q, full, empty, 8'(fill_q)};
                default:         result_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            period_q <= 32'd0;
            armed_q  <= 1'b0;
            timer_q  <= 32'd0;
            ovf_q    <= 16'd0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            period_q <= period_d;
            armed_q  <= armed_d;
            timer_q  <= timer_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= {counterValue3, counterValue2, counterValue1, counterValue0};
    end

`ifdef PROFILE_SAMPLER_TIMESTAMP_EN
    always_ff @(posedge clock) begin
        if (reset) ts_q <= 32'd0;
        else       ts_q <= ts_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (do_push) ts_mem_q[wr_ptr_q] <= ts_q;
    end
`endif

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_profile_sampler.sv
// Self-checking bench for profile_sampler: vector table plus hand sequences, results matched through a scoreboard queue.
module tb_profile_sampler;

    localparam logic [7:0] ID = 8'h5A;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA, valueB;
    logic [31:0] counterValue0, counterValue1, counterValue2, counterValue3;
    logic        done;
    logic [31:0] result;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb_q[$];

    profile_sampler #(.customId(ID), .DEPTH(8)) dut (
        .clock(clock), .reset(reset), .start(start), .ciN(ciN),
        .valueA(valueA), .valueB(valueB),
        .counterValue0(counterValue0), .counterValue1(counterValue1),
        .counterValue2(counterValue2), .counterValue3(counterValue3),
        .done(done), .result(result)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        st;
        logic [7:0]  ci;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] cb;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_counters(input logic [31:0] base);
        counterValue0 = base;
        counterValue1 = base + 32'd1;
        counterValue2 = base + 32'd2;
        counterValue3 = base + 32'd3;
    endtask

    // One clock: drive inputs, queue the expected result, then check after the edge
    task automatic drive(input string name, input logic st, input logic [7:0] ci,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic exp_done, input logic [31:0] exp_res);
        logic [31:0] e;
        start  = st;
        ciN    = ci;
        valueA = va;
        valueB = vb;
        if (exp_done) sb_q.push_back(exp_res);
        @(posedge clock);
        #1;
        start = 1'b0;
        check({name, " done"}, 32'(done), 32'(exp_done));
        if (done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s result: done with no pending expectation, got %h", name, result);
            end else begin
                e = sb_q.pop_front();
                check({name, " result"}, result, e);
            end
        end else begin
            check({name, " idle result"}, result, 32'd0);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [7:0] ci, input logic [31:0] va,
                                input logic [31:0] vb, input logic [31:0] cb, input logic [31:0] exp);
        vec_t v;
        v.st = st; v.ci = ci; v.va = va; v.vb = vb; v.cb = cb; v.exp = exp;
        return v;
    endfunction

    vec_t        tbl[18];
    logic [31:0] pushed[20];

    initial begin
        // op field lives in valueA[3:2]: peek=0x0, pop=0x4, config=0x8, status=0xC
        tbl[0]  = mk(1'b1, ID,    32'hC,  32'd0, 32'h10, 32'h0000_0100); // status after reset
        tbl[1]  = mk(1'b1, ID,    32'h4,  32'd0, 32'h10, 32'h0);         // pop on empty
        tbl[2]  = mk(1'b1, ID,    32'hC,  32'd0, 32'h10, 32'h0000_0100); // still empty
        tbl[3]  = mk(1'b1, 8'h11, 32'hC,  32'd0, 32'h10, 32'h0);         // foreign ciN
        tbl[4]  = mk(1'b1, ID,    32'h8,  32'd4, 32'h10, 32'h0);         // config period 4
        tbl[5]  = mk(1'b0, ID,    32'h0,  32'd0, 32'h10, 32'h0);
        tbl[6]  = mk(1'b0, ID,    32'h0,  32'd0, 32'h10, 32'h0);
        tbl[7]  = mk(1'b0, ID,    32'h0,  32'd0, 32'h10, 32'h0);
        tbl[8]  = mk(1'b1, ID,    32'h0,  32'd0, 32'h10, 32'h0);         // peek racing first push
        tbl[9]  = mk(1'b1, ID,    32'h0,  32'd0, 32'h10, 32'h10);        // peek word 0
        tbl[10] = mk(1'b1, ID,    32'h3,  32'd0, 32'h10, 32'h13);        // peek word 3
        tbl[11] = mk(1'b1, ID,    32'hC,  32'd0, 32'h10, 32'h0000_0401); // armed, fill 1
        tbl[12] = mk(1'b1, ID,    32'h5,  32'd0, 32'hA0, 32'h11);        // pop word 1 with push
        tbl[13] = mk(1'b1, ID,    32'h2,  32'd0, 32'hA0, 32'hA2);        // new head
        tbl[14] = mk(1'b1, ID,    32'h14, 32'd0, 32'hA0, 32'h0);         // timestamp pop
        tbl[15] = mk(1'b1, ID,    32'h0,  32'd0, 32'hA0, 32'h0);         // now empty
        tbl[16] = mk(1'b1, ID,    32'h8,  32'd0, 32'hA0, 32'h0);         // disarm on wrap edge
        tbl[17] = mk(1'b1, ID,    32'hC,  32'd0, 32'hA0, 32'h0000_0100); // no sample pushed

        reset = 1'b1;
        start = 1'b0; ciN = 8'h0; valueA = 32'h0; valueB = 32'h0;
        set_counters(32'h0);
        for (int i = 0; i < 3; i++) drive("reset", 1'b0, ID, 32'h0, 32'h0, 1'b0, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            set_counters(tbl[i].cb);
            drive($sformatf("vec%0d", i), tbl[i].st, tbl[i].ci, tbl[i].va, tbl[i].vb,
                  tbl[i].st && (tbl[i].ci == ID), tbl[i].exp);
        end

        // Period 1 saturation: 20 pushes into 8 slots
        set_counters(32'h1000);
        drive("cfg1", 1'b1, ID, 32'h8, 32'd1, 1'b1, 32'h0);
        for (int i = 0; i < 20; i++) begin
            counterValue0 = 32'h2000 + 32'(i);
            pushed[i] = counterValue0;
            drive("fill", 1'b0, ID, 32'h0, 32'h0, 1'b0, 32'h0);
        end
        counterValue0 = 32'h3000;
        drive("status_full", 1'b1, ID, 32'hC, 32'h0, 1'b1, 32'h000C_0608);
        for (int i = 0; i < 4; i++) begin
            counterValue0 = 32'h3100 + 32'(i);
            drive($sformatf("pop_full%0d", i), 1'b1, ID, 32'h4, 32'h0, 1'b1, pushed[i]);
        end
        drive("status_pop", 1'b1, ID, 32'hC, 32'h0, 1'b1, 32'h000D_0608);
        drive("peek_full", 1'b1, ID, 32'h0, 32'h0, 1'b1, pushed[4]);

        // Reset in the same cycle as a pop cancels it
        reset = 1'b1;
        drive("rst_pop", 1'b1, ID, 32'h4, 32'h0, 1'b0, 32'h0);
        reset = 1'b0;
        drive("rst_after", 1'b0, ID, 32'h0, 32'h0, 1'b0, 32'h0);
        drive("rst_status", 1'b1, ID, 32'hC, 32'h0, 1'b1, 32'h0000_0100);
        drive("rst_peek", 1'b1, ID, 32'h0, 32'h0, 1'b1, 32'h0);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/profile_sampler.md
PROFILE_SAMPLER -- requirements
Module: profile_sampler

Interface
REQ-001 SHALL provide parameter customId, default 8'h00, the custom-instruction number the block answers to.
REQ-002 SHALL provide parameter DEPTH, default 8, the FIFO entry count; legal values are powers of two from 2 to 64.
REQ-003 SHALL have port clock, input, 1 bit, rising-edge clock.
REQ-004 SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit, one-cycle custom-instruction request strobe.
REQ-006 SHALL have port ciN, input, 8 bits, custom-instruction number.
REQ-007 SHALL have port valueA, input, 32 bits: [1:0] word select, [3:2] opcode, [4] timestamp select.
REQ-008 SHALL have port valueB, input, 32 bits, configuration operand.
REQ-009 SHALL have ports counterValue0..counterValue3, input, 32 bits each, live profiling counter values.
REQ-010 SHALL have port done, output, 1 bit, completion strobe.
REQ-011 SHALL have port result, output, 32 bits, instruction result.

Function
REQ-012 SHALL accept a request only in a cycle where start=1 and ciN==customId; valueA and valueB SHALL be sampled in that cycle.
REQ-013 SHALL assert done for exactly one cycle, on the cycle after an accepted request; result SHALL be valid in that cycle and 0 in all other cycles.
REQ-014 Opcode 00 (peek) SHALL return word valueA[1:0] (counterValue0..3) of the head entry and SHALL leave the FIFO unchanged.
REQ-015 Opcode 01 (pop) SHALL return the same word as peek and SHALL remove the head entry at the accepting edge.
REQ-016 Opcode 10 (config) SHALL load period := valueB, set armed := (valueB != 0), clear timer and overflow count, and return 0.
REQ-017 Opcode 11 (status) SHALL return {overflow[15:0], 5'b0, armed, full, empty, fill[7:0]}.
REQ-018 Peek or pop on an empty FIFO SHALL return 0; pop on an empty FIFO SHALL be ignored.
REQ-019 When armed, timer SHALL count 0..period-1; at an edge with timer==period-1 it SHALL push {counterValue3..0} as one entry and reset timer to 0; period=1 SHALL sample every cycle.
REQ-020 A push attempted while the FIFO is full SHALL be dropped, and overflow SHALL increment, saturating at 16'hFFFF.
REQ-021 A push and a pop at the same edge on a non-empty FIFO SHALL both occur, leaving fill unchanged; this SHALL hold when full.
REQ-022 A push and a read at the same edge on an empty FIFO SHALL return 0; the pushed entry SHALL be visible from the next cycle.
REQ-023 A config at the same edge as a timer wrap SHALL take precedence: the timer SHALL clear and no sample SHALL be pushed.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; fill SHALL range from 0 to DEPTH.

Reset
REQ-025 Reset SHALL clear FIFO pointers, fill, period, armed, timer, overflow, timestamp, done and result to 0.
REQ-026 Reset asserted in the same cycle as an accepted request SHALL cancel it: no done SHALL follow and no pop SHALL occur.

Configuration
REQ-027 Macro PROFILE_SAMPLER_TIMESTAMP_EN defined: a free-running 32-bit cycle counter SHALL be stored with each entry; peek or pop with valueA[4]=1 SHALL return that entry's timestamp.
REQ-028 Macro PROFILE_SAMPLER_TIMESTAMP_EN undefined: no timestamp storage SHALL exist; valueA[4]=1 peek or pop SHALL return 0, and pop SHALL still remove the head entry.

Verification
REQ-029 Config with valueB=4, counterValue0=32'h10 held -> first entry pushed 4 cycles after config; peek word 0 returns 32'h10; done high exactly 1 cycle.
REQ-030 DEPTH=8, period=1, no pops for 20 cycles -> status returns fill=8, full=1, overflow=12.
REQ-031 Pop on empty FIFO -> result=0, status fill=0, empty=1; no pointer change.
REQ-032 FIFO full with period=1, pop every cycle -> fill stays 8 and overflow stays constant.
REQ-033 Reset in the start cycle of a pop -> done stays 0; status afterwards returns 32'h00000100 (empty only).
REQ-034 Request with ciN != customId -> done=0, result=0; FIFO unchanged.
